// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Issues one outstanding request at a
//               time to instruction memory, forwards returned words to decode
//               with their PC, buffers one word while decode is stalled and
//               redirects on flush, dropping any word fetched before it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  IWIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                fs_clk,
    input  logic                fs_rst,
    output logic                fs_o_imem_req,
    output logic [PC_WIDTH-1:0] fs_o_imem_addr,
    input  logic                fs_i_imem_ack,
    input  logic [IWIDTH-1:0]   fs_i_imem_data,
    output logic [IWIDTH-1:0]   fs_o_instr,
    output logic [PC_WIDTH-1:0] fs_o_pc,
    output logic                fs_o_ce,
    input  logic                fs_i_stall,
    input  logic                fs_i_flush,
    input  logic [PC_WIDTH-1:0] fs_i_new_pc
);

    localparam logic [PC_WIDTH-1:0] c_PC_STEP    = PC_WIDTH'(4);
    localparam logic [PC_WIDTH-1:0] c_ALIGN_MASK = ~(PC_WIDTH'(3));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // first cycle after reset release
        S_REQ     = 2'd1,   // request outstanding
        S_HOLD    = 2'd2,   // returned word parked while decode stalls
        S_DISCARD = 2'd3    // waiting out the ack of a flushed request
    } state_t;

    state_t                state_q;
    logic                  req_q;
    logic [PC_WIDTH-1:0]   addr_q;
    logic [IWIDTH-1:0]     instr_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic                  ce_q;
    logic [IWIDTH-1:0]     buf_data_q;
    logic [PC_WIDTH-1:0]   buf_addr_q;
    // Next fetch address when no request is in flight: RESET_PC out of reset,
    // the redirect target while a flushed request drains.
    logic [PC_WIDTH-1:0]   next_pc_q;

    // Redirect target, always word aligned.
    logic [PC_WIDTH-1:0]   w_flush_pc;
    assign w_flush_pc = fs_i_new_pc & c_ALIGN_MASK;

    // Fetch control FSM; every output is registered here.
    always_ff @(posedge fs_clk) begin
        if (!fs_rst) begin
            state_q    <= S_IDLE;
            next_pc_q  <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            pc_q       <= '0;
            ce_q       <= 1'b0;
            buf_data_q <= '0;
            buf_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Any ack seen here belongs to a request abandoned by reset.
                    ce_q    <= 1'b0;
                    req_q   <= 1'b1;
                    addr_q  <= fs_i_flush ? w_flush_pc : next_pc_q;
                    state_q <= S_REQ;
                end

                S_REQ: begin
                    if (fs_i_flush) begin
                        ce_q <= 1'b0;
                        if (fs_i_imem_ack) begin
                            // Returning word is dropped, restart at target.
                            addr_q  <= w_flush_pc;
                            state_q <= S_REQ;
                        end else begin
                            // Request must stay stable until acked; remember target.
                            next_pc_q <= w_flush_pc;
                            state_q   <= S_DISCARD;
                        end
                    end else if (fs_i_imem_ack) begin
                        if (!fs_i_stall) begin
                            instr_q <= fs_i_imem_data;
                            pc_q    <= addr_q;
                            ce_q    <= 1'b1;
                            addr_q  <= addr_q + c_PC_STEP;
                        end else begin
                            // Decode busy: park the word, stop fetching.
                            buf_data_q <= fs_i_imem_data;
                            buf_addr_q <= addr_q;
                            req_q      <= 1'b0;
                            state_q    <= S_HOLD;
                        end
                    end else if (!fs_i_stall) begin
                        ce_q <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (fs_i_flush) begin
                        ce_q    <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= w_flush_pc;
                        state_q <= S_REQ;
                    end else if (!fs_i_stall) begin
                        instr_q <= buf_data_q;
                        pc_q    <= buf_addr_q;
                        ce_q    <= 1'b1;
                        req_q   <= 1'b1;
                        addr_q  <= buf_addr_q + c_PC_STEP;
                        state_q <= S_REQ;
                    end
                end

                S_DISCARD: begin
                    ce_q <= 1'b0;
                    if (fs_i_imem_ack) begin
                        addr_q  <= fs_i_flush ? w_flush_pc : next_pc_q;
                        state_q <= S_REQ;
                    end else if (fs_i_flush) begin
                        next_pc_q <= w_flush_pc;
                    end
                end

                default: begin
                    req_q   <= 1'b0;
                    ce_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fs_o_imem_req  = req_q;
    assign fs_o_imem_addr = addr_q;
    assign fs_o_instr     = instr_q;
    assign fs_o_pc        = pc_q;
    assign fs_o_ce        = ce_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a latency-randomised
//               memory responder and a program-order reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        ack;
    logic [31:0] mdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ce;

    // Second instance: wrap-around start address, zero-wait memory.
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic        ce2;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder controls
    bit mem_en    = 1'b0;
    bit junk_ack  = 1'b0;
    int mem_min   = 0;
    int mem_max   = 0;
    bit busy      = 1'b0;
    int left      = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0000_0000)) u_dut (
        .fs_clk        (clk),
        .fs_rst        (rst_n),
        .fs_o_imem_req (req),
        .fs_o_imem_addr(addr),
        .fs_i_imem_ack (ack),
        .fs_i_imem_data(mdata),
        .fs_o_instr    (instr),
        .fs_o_pc       (pc),
        .fs_o_ce       (ce),
        .fs_i_stall    (stall),
        .fs_i_flush    (flush),
        .fs_i_new_pc   (new_pc)
    );

    fetch_stage #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .fs_clk        (clk),
        .fs_rst        (rst_n),
        .fs_o_imem_req (req2),
        .fs_o_imem_addr(addr2),
        .fs_i_imem_ack (req2),
        .fs_i_imem_data(addr2),
        .fs_o_instr    (instr2),
        .fs_o_pc       (pc2),
        .fs_o_ce       (ce2),
        .fs_i_stall    (1'b0),
        .fs_i_flush    (1'b0),
        .fs_i_new_pc   (32'h0)
    );

    // Memory contents: a fixed function of the address, word 0 = 0x003100B3.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0031_00B3;
    endfunction

    // Memory: after each edge, decide whether the current request is acked
    // before the next edge, with a latency drawn from [mem_min, mem_max].
    always @(posedge clk) begin
        #1;
        if (!mem_en) begin
            ack   = junk_ack;
            mdata = 32'hDEAD_BEEF;
            busy  = 1'b0;
        end else if (req) begin
            if (!busy) begin
                busy = 1'b1;
                left = int'($urandom_range(mem_max, mem_min));
            end
            if (left == 0) begin
                ack   = 1'b1;
                mdata = word_of(addr);
                busy  = 1'b0;
            end else begin
                ack   = 1'b0;
                mdata = $urandom;
                left  = left - 1;
            end
        end else begin
            ack  = 1'b0;
            busy = 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        mem_en   = 1'b0;
        junk_ack = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (req   !== 1'b0)  begin n_fail++; $display("FAIL reset_req got %0b want 0", req); end
        n_tests++; if (addr  !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
        n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
        n_tests++; if (pc    !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
        n_tests++; if (ce    !== 1'b0)  begin n_fail++; $display("FAIL reset_ce got %0b want 0", ce); end
        rst_n = 1'b1;
        @(negedge clk);
        // Ack held high through reset and IDLE must not produce a word.
        n_tests++; if (req !== 1'b1 || addr !== 32'h0 || ce !== 1'b0) begin
            n_fail++; $display("FAIL idle_issue got req=%0b addr=%h ce=%0b want 1 0 0", req, addr, ce);
        end
        junk_ack = 1'b0;
    endtask

    task automatic test_zero_wait();
        int got = 0;
        int first = -1;
        bit gap_bad = 1'b0;
        mem_en = 1'b1; mem_min = 0; mem_max = 0;
        apply_reset();
        for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
            @(negedge clk);
            if (ce) begin
                if (first < 0) first = cyc;
                if (cyc != first + got) gap_bad = 1'b1;
                n_tests++;
                if (pc !== 32'(got * 4) || instr !== word_of(32'(got * 4))) begin
                    n_fail++; $display("FAIL zw_word got pc=%h instr=%h want pc=%h instr=%h",
                                       pc, instr, 32'(got * 4), word_of(32'(got * 4)));
                end
                got++;
            end
        end
        n_tests++; if (got != 4 || gap_bad) begin
            n_fail++; $display("FAIL zw_stream got %0d words gap_bad=%0b want 4 consecutive", got, gap_bad);
        end
        n_tests++; if (first != 1) begin
            n_fail++; $display("FAIL zw_latency got first ce at cycle %0d want 1", first);
        end
    endtask

    task automatic test_delay3();
        int got = 0;
        int last = -1;
        bit gap_bad = 1'b0;
        bit stab_bad = 1'b0;
        logic        p_req = 1'b0;
        logic        p_ack = 1'b0;
        logic [31:0] p_addr = '0;
        mem_en = 1'b1; mem_min = 3; mem_max = 3;
        apply_reset();
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (p_req && !p_ack && (req !== 1'b1 || addr !== p_addr)) stab_bad = 1'b1;
            if (ce) begin
                if (last >= 0 && cyc - last != 4) gap_bad = 1'b1;
                if (pc !== 32'(got * 4)) gap_bad = 1'b1;
                last = cyc;
                got++;
            end
            p_req = req; p_ack = ack; p_addr = addr;
        end
        n_tests++; if (gap_bad || got < 12) begin
            n_fail++; $display("FAIL d3_rate got %0d words gap_bad=%0b want >=12 one per 4 cycles", got, gap_bad);
        end
        n_tests++; if (stab_bad) begin
            n_fail++; $display("FAIL d3_req_stable got unstable=1 want 0");
        end
    endtask

    task automatic test_reset_midflight();
        mem_en = 1'b1; mem_min = 3; mem_max = 3;
        apply_reset();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (req !== 1'b0 || ce !== 1'b0) begin
            n_fail++; $display("FAIL midrst got req=%0b ce=%0b want 0 0", req, ce);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (req !== 1'b1 || addr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_restart got req=%0b addr=%h want 1 0", req, addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic        ce0;
        logic [31:0] pc0;
        logic [31:0] in0;
        bit found = 1'b0;
        bit seen = 1'b0;
        mem_en = 1'b1; mem_min = 1; mem_max = 1;
        apply_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req && ack && addr != 32'h0) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL stall_setup got no ack want ack"); end
        a = addr; ce0 = ce; pc0 = pc; in0 = instr;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++; if (ce !== ce0 || pc !== pc0 || instr !== in0 || req !== 1'b0) begin
                n_fail++; $display("FAIL stall_freeze got ce=%0b pc=%h req=%0b want ce=%0b pc=%h req=0",
                                   ce, pc, req, ce0, pc0);
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_tests++; if (ce !== 1'b1 || pc !== a || instr !== word_of(a)) begin
            n_fail++; $display("FAIL stall_release got ce=%0b pc=%h instr=%h want 1 %h %h",
                               ce, pc, instr, a, word_of(a));
        end
        n_tests++; if (req !== 1'b1 || addr !== a + 32'd4) begin
            n_fail++; $display("FAIL stall_next_req got req=%0b addr=%h want 1 %h", req, addr, a + 32'd4);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ce) begin
                seen = 1'b1;
                n_tests++; if (pc !== a + 32'd4) begin
                    n_fail++; $display("FAIL stall_no_dup got pc=%h want %h", pc, a + 32'd4);
                end
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL stall_timeout got no word want word"); end
    endtask

    task automatic test_flush_pending();
        logic [31:0] a;
        bit found = 1'b0;
        bit acked = 1'b0;
        bit bad_ce = 1'b0;
        bit seen = 1'b0;
        mem_en = 1'b1; mem_min = 3; mem_max = 3;
        apply_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (req && !ack) found = 1'b1;
        end
        a = addr;
        flush = 1'b1; new_pc = 32'h0000_0102;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (ce !== 1'b0 || req !== 1'b1 || addr !== a) begin
            n_fail++; $display("FAIL flush_hold got ce=%0b req=%0b addr=%h want 0 1 %h", ce, req, addr, a);
        end
        for (int i = 0; i < 20 && !acked; i++) begin
            if (ce) bad_ce = 1'b1;
            if (ack) acked = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (!acked || req !== 1'b1 || addr !== 32'h0000_0100) begin
            n_fail++; $display("FAIL flush_redirect got acked=%0b req=%0b addr=%h want 1 1 00000100", acked, req, addr);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            if (ce) begin
                seen = 1'b1;
                n_tests++; if (pc !== 32'h0000_0100 || instr !== word_of(32'h0000_0100)) begin
                    n_fail++; $display("FAIL flush_first_word got pc=%h instr=%h want 00000100 %h",
                                       pc, instr, word_of(32'h0000_0100));
                end
            end else begin
                @(negedge clk);
            end
        end
        n_tests++; if (bad_ce || !seen) begin
            n_fail++; $display("FAIL flush_dropped got stale_ce=%0b seen=%0b want 0 1", bad_ce, seen);
        end
    endtask

    task automatic test_flush_stall();
        bit seen = 1'b0;
        mem_en = 1'b1; mem_min = 1; mem_max = 1;
        apply_reset();
        repeat (6) @(negedge clk);
        stall = 1'b1; flush = 1'b1; new_pc = 32'h0000_0203;
        @(negedge clk);
        flush = 1'b0;
        n_tests++; if (ce !== 1'b0) begin n_fail++; $display("FAIL fs_ce got %0b want 0", ce); end
        repeat (2) @(negedge clk);
        stall = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ce) begin
                seen = 1'b1;
                n_tests++; if (pc !== 32'h0000_0200) begin
                    n_fail++; $display("FAIL fs_redirect got pc=%h want 00000200", pc);
                end
            end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL fs_timeout got no word want word"); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        int consumed = 0;
        int bad = 0;
        logic        p_req = 1'b0;
        logic        p_ack = 1'b0;
        logic [31:0] p_addr = '0;
        mem_en = 1'b1; mem_min = 0; mem_max = 3;
        apply_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (p_req && !p_ack) begin
                n_tests++;
                if (req !== 1'b1 || addr !== p_addr) begin
                    n_fail++;
                    if (bad++ < 5) $display("FAIL rnd_req_stable got req=%0b addr=%h want 1 %h", req, addr, p_addr);
                end
            end
            if (ce && !stall) begin
                n_tests++;
                if (pc !== exp_pc || instr !== word_of(exp_pc)) begin
                    n_fail++;
                    if (bad++ < 5) $display("FAIL rnd_word got pc=%h instr=%h want %h %h",
                                            pc, instr, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end
            if (flush) exp_pc = new_pc & 32'hFFFF_FFFC;
            p_req = req; p_ack = ack; p_addr = addr;
            stall  = ($urandom_range(3, 0) == 0);
            flush  = ($urandom_range(29, 0) == 0);
            new_pc = $urandom;
        end
        stall = 1'b0; flush = 1'b0;
        n_tests++; if (consumed < 200) begin
            n_fail++; $display("FAIL rnd_progress got %0d words want >=200", consumed);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pcs [3];
        int got = 0;
        exp_pcs[0] = 32'hFFFF_FFF8;
        exp_pcs[1] = 32'hFFFF_FFFC;
        exp_pcs[2] = 32'h0000_0000;
        apply_reset();
        for (int i = 0; i < 20 && got < 3; i++) begin
            @(negedge clk);
            if (ce2) begin
                n_tests++;
                if (pc2 !== exp_pcs[got] || instr2 !== exp_pcs[got]) begin
                    n_fail++; $display("FAIL wrap_pc got pc=%h instr=%h want %h", pc2, instr2, exp_pcs[got]);
                end
                got++;
            end
        end
        n_tests++; if (got != 3) begin n_fail++; $display("FAIL wrap_count got %0d want 3", got); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; new_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_delay3();
        test_reset_midflight();
        test_stall();
        test_flush_pending();
        test_flush_stall();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
